// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial-arithmetic blocks: FSM state encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit full subtractor: D = A - B - bin, with borrow out.
module one_bit_fullsubtractor (
  input  logic A,
  input  logic B,
  input  logic bin,
  output logic D,
  output logic bout
);

  always_comb begin
    D    = A ^ B ^ bin;
    bout = (~A & B) | (~(A ^ B) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock; result, borrow and signed overflow held until the next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] d_sh;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             d_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] d_cat;

  one_bit_fullsubtractor u_fullsub (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .bin  (borrow),
    .D    (d_bit),
    .bout (borrow_nxt)
  );

  // d_sh keeps only the WIDTH-1 bits produced so far; the current bit completes the word.
  assign d_cat = {d_bit, d_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          borrow <= borrow_nxt;
          d_sh   <= d_cat[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= d_cat;
            bout  <= borrow_nxt;
            ovf   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
